// File: rtl/median_pkg.sv
// Shared constants and state type for the median filter front end and filter core.
package median_pkg;
    localparam int unsigned ROW      = 256;
    localparam int unsigned COL      = 256;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned BUS_W    = 32;
    localparam int unsigned ROW_BITS = ROW * WIDTH * 3;
    localparam int unsigned WORDS    = ROW_BITS / BUS_W;
    localparam logic [8:0]  STROBE   = 9'd192;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PUBLISH,
        FLUSH,
        DONE
    } state_t;
endpackage

// File: rtl/median_row_assembler_packer.sv
// Row fill register: one bus word written per cycle at a word index, with synchronous clear.
module row_word_packer
    import median_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [7:0]          idx,
    input  logic [BUS_W-1:0]    word,
    output logic [ROW_BITS-1:0] fill
);

    // Word 0 lands in the most significant slot so the row reads in raster order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else begin
            if (clr) begin
                fill <= '0;
            end
            if (we) begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (idx == 8'(i)) begin
                        fill[ROW_BITS-1-BUS_W*i -: BUS_W] <= word;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/median_row_assembler.sv
// Packs the 32-bit pixel stream into 6144-bit rows, strobes each row and the end-of-frame flush.
module median_row_assembler
    import median_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BUS_W-1:0]    s_data,
    input  logic                s_sof,
    output logic [ROW_BITS-1:0] row_out,
    output logic [8:0]          buffer_counter,
    output logic                en_out,
    output logic [8:0]          row_count,
    output logic                frame_done,
    output logic                sof_err
);

    state_t                state;
    state_t                state_nx;
    logic                  acc;
    logic                  sof_acc;
    logic                  word_acc;
    logic                  last_word;
    logic [7:0]            wr_idx;
    logic [ROW_BITS-1:0]   fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (sof_acc)   state_nx = FILL;
            FILL:       if (last_word) state_nx = PUBLISH;
            PUBLISH:    state_nx = (row_count == 9'(COL - 1)) ? FLUSH : FILL;
            FLUSH:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // The strobe value 192 in FILL means the fill buffer is empty again.
    always_comb begin
        s_ready   = (state == IDLE) || (state == FILL) || (state == DONE);
        acc       = s_valid && s_ready;
        sof_acc   = acc && s_sof;
        word_acc  = acc && !s_sof && (state == FILL);
        wr_idx    = (buffer_counter == STROBE) ? '0 : buffer_counter[7:0];
        last_word = word_acc && (wr_idx == 8'(WORDS - 1));
    end

    row_word_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  (sof_acc),
        .we   (sof_acc || word_acc),
        .idx  (sof_acc ? 8'd0 : wr_idx),
        .word (s_data),
        .fill (fill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_out        <= '0;
            buffer_counter <= '0;
            en_out         <= 1'b0;
            row_count      <= '0;
            frame_done     <= 1'b0;
            sof_err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            if (sof_acc) begin
                buffer_counter <= 9'd1;
                en_out         <= 1'b0;
                row_count      <= '0;
                sof_err        <= (state == FILL) && (wr_idx != '0);
            end else begin
                unique case (state)
                    FILL: begin
                        en_out <= 1'b1;
                        if (word_acc) begin
                            buffer_counter <= last_word ? '0 : 9'(wr_idx) + 9'd1;
                        end else if (buffer_counter == STROBE) begin
                            buffer_counter <= '0;
                        end
                    end
                    PUBLISH: begin
                        row_out        <= fill;
                        buffer_counter <= STROBE;
                        row_count      <= row_count + 9'd1;
                    end
                    FLUSH: begin
                        buffer_counter <= STROBE;
                        frame_done     <= 1'b1;
                    end
                    DONE:    buffer_counter <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule
